// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants and helpers for the data-memory arbiter.
//   REQ_M0 / REQ_M1    : requester indices (CPU LSU = 0, DMA/debug = 1)
//   *_WIDTH_DEF        : default address, data and stall-counter widths
//   addr_aligned()     : word-alignment check on the two address LSBs
package dmem_arb_pkg;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam int unsigned A_WIDTH_DEF   = 32'd32;
    localparam int unsigned D_WIDTH_DEF   = 32'd32;
    localparam int unsigned CNT_WIDTH_DEF = 32'd16;

    // A request is issued to memory only when its byte address is word aligned.
    function automatic logic addr_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : contenders (bit index = requester index)
//   gnt[1:0]   : one-hot winner, combinational from req and the last-winner register
// A sole contender always wins; on contention the requester that did not win
// last time is chosen. Reset makes requester 1 the last winner so requester 0
// wins the first contention.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_r;

    // Winner selection from the contenders and the last-winner pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_r == REQ_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Last-winner pointer, updated on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= REQ_M1;
        end else if (gnt != 2'b00) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the dual-port data memory between the CPU LSU (m0) and
// the DMA/debug engine (m1). Writes and reads are arbitrated independently, so
// one write and one read from different requesters can issue in one cycle.
//   mX_req/we/addr/wdata : request from requester X (held until gnt)
//   mX_gnt, mX_err       : accept this cycle / accepted but misaligned (comb)
//   mX_rvalid, mX_rdata  : read return, one cycle after an aligned read accept
//   mX_stall_cnt         : saturating count of cycles with req and no gnt
//   mem_we/w_addr/w_data : memory write port
//   mem_re/r_addr        : memory read port; mem_r_data returns one cycle later
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned A_WIDTH   = A_WIDTH_DEF,
    parameter int unsigned D_WIDTH   = D_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [A_WIDTH-1:0]   m0_addr,
    input  logic [D_WIDTH-1:0]   m0_wdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [A_WIDTH-1:0]   m1_addr,
    input  logic [D_WIDTH-1:0]   m1_wdata,
    output logic                 m0_gnt,
    output logic                 m1_gnt,
    output logic                 m0_err,
    output logic                 m1_err,
    output logic                 m0_rvalid,
    output logic                 m1_rvalid,
    output logic [D_WIDTH-1:0]   m0_rdata,
    output logic [D_WIDTH-1:0]   m1_rdata,
    output logic [CNT_WIDTH-1:0] m0_stall_cnt,
    output logic [CNT_WIDTH-1:0] m1_stall_cnt,
    output logic                 mem_we,
    output logic [A_WIDTH-1:0]   mem_w_addr,
    output logic [D_WIDTH-1:0]   mem_w_data,
    output logic                 mem_re,
    output logic [A_WIDTH-1:0]   mem_r_addr,
    input  logic [D_WIDTH-1:0]   mem_r_data
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]           req_s;
    logic [1:0]           wr_req_s;
    logic [1:0]           rd_req_s;
    logic [1:0]           wr_gnt_s;
    logic [1:0]           rd_gnt_s;
    logic [1:0]           gnt_s;
    logic [1:0]           aligned_s;
    logic                 mem_we_s;
    logic                 mem_re_s;
    logic                 rd_pend_r;
    logic                 rd_owner_r;
    logic [CNT_WIDTH-1:0] stall_cnt_r [2];

    // Requests are masked while reset is held so no grant leaks out of reset.
    assign req_s     = {m1_req, m0_req} & {2{rst_n}};
    assign wr_req_s  = req_s & {m1_we, m0_we};
    assign rd_req_s  = req_s & ~{m1_we, m0_we};
    assign aligned_s = {addr_aligned(m1_addr[1:0]), addr_aligned(m0_addr[1:0])};

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req_s),
        .gnt   (wr_gnt_s)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req_s),
        .gnt   (rd_gnt_s)
    );

    // A requester has a single request, so at most one class grants it.
    assign gnt_s  = wr_gnt_s | rd_gnt_s;
    assign m0_gnt = gnt_s[0];
    assign m1_gnt = gnt_s[1];
    assign m0_err = gnt_s[0] & ~aligned_s[0];
    assign m1_err = gnt_s[1] & ~aligned_s[1];

    // Write port mux: misaligned winners are granted but never reach memory.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_w_addr = m0_addr;
        mem_w_data = m0_wdata;
        if (wr_gnt_s[1]) begin
            mem_we_s   = aligned_s[1];
            mem_w_addr = m1_addr;
            mem_w_data = m1_wdata;
        end else if (wr_gnt_s[0]) begin
            mem_we_s   = aligned_s[0];
        end else begin
            mem_we_s   = 1'b0;
        end
    end

    // Read port mux, same masking of misaligned winners as the write port.
    always_comb begin
        mem_re_s   = 1'b0;
        mem_r_addr = m0_addr;
        if (rd_gnt_s[1]) begin
            mem_re_s   = aligned_s[1];
            mem_r_addr = m1_addr;
        end else if (rd_gnt_s[0]) begin
            mem_re_s   = aligned_s[0];
        end else begin
            mem_re_s   = 1'b0;
        end
    end

    assign mem_we = mem_we_s;
    assign mem_re = mem_re_s;

    // Read-response tracking: remember that a read issued and who owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= REQ_M0;
        end else begin
            rd_pend_r  <= mem_re_s;
            rd_owner_r <= rd_gnt_s[1];
        end
    end

    assign m0_rvalid = rd_pend_r & (rd_owner_r == REQ_M0);
    assign m1_rvalid = rd_pend_r & (rd_owner_r == REQ_M1);
    assign m0_rdata  = mem_r_data;
    assign m1_rdata  = mem_r_data;

    // Saturating stall counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r[0] <= '0;
            stall_cnt_r[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_s[i] && !gnt_s[i] && (stall_cnt_r[i] != CNT_MAX)) begin
                    stall_cnt_r[i] <= stall_cnt_r[i] + CNT_ONE;
                end else begin
                    stall_cnt_r[i] <= stall_cnt_r[i];
                end
            end
        end
    end

    assign m0_stall_cnt = stall_cnt_r[0];
    assign m1_stall_cnt = stall_cnt_r[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, self-checking bench for dmem_arbiter with a
// behavioural data memory, a cycle model of the arbitration and a scoreboard
// of expected read data per requester.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_err, m1_err, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [CW-1:0] m0_stall_cnt, m1_stall_cnt;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data, mem_r_data;

    logic          mem_fill;
    logic [DW-1:0] mem [64];

    dmem_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_err(m0_err), .m1_err(m1_err),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_re(mem_re), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory with write-through on same-address read/write.
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + 32'(i);
            mem_r_data <= 32'h0;
        end else begin
            if (mem_we) mem[mem_w_addr[7:2]] <= mem_w_data;
            if (mem_re) mem_r_data <= (mem_we && (mem_w_addr == mem_r_addr)) ?
                                      mem_w_data : mem[mem_r_addr[7:2]];
        end
    end

    int            n_checks;
    int            n_errors;
    logic [DW-1:0] exp_mem [64];
    logic          ptr_w, ptr_r;
    int            ecnt0, ecnt1;
    logic          erv0, erv1;
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ptr_w = 1'b1;
        ptr_r = 1'b1;
        ecnt0 = 0;
        ecnt1 = 0;
        erv0  = 1'b0;
        erv1  = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    // One clock cycle: check combinational outputs against the model, advance
    // the model at the edge, then check registered outputs. kill asserts reset
    // just after the edge.
    task automatic tick(input bit kill);
        logic v0, v1, vw0, vw1, vr0, vr1, gw0, gw1, gr0, gr1, g0, g1, al0, al1, e_we, e_re;
        logic [31:0] wa, wd, ra, rexp;
        #1;
        v0  = rst_n & m0_req;  v1 = rst_n & m1_req;
        vw0 = v0 & m0_we;      vw1 = v1 & m1_we;
        vr0 = v0 & ~m0_we;     vr1 = v1 & ~m1_we;
        if (vw0 && vw1) begin gw0 = ptr_w; gw1 = ~ptr_w; end else begin gw0 = vw0; gw1 = vw1; end
        if (vr0 && vr1) begin gr0 = ptr_r; gr1 = ~ptr_r; end else begin gr0 = vr0; gr1 = vr1; end
        g0 = gw0 | gr0;  g1 = gw1 | gr1;
        al0 = (m0_addr[1:0] == 2'b00);
        al1 = (m1_addr[1:0] == 2'b00);
        e_we = (gw0 & al0) | (gw1 & al1);
        e_re = (gr0 & al0) | (gr1 & al1);
        chk("m0_gnt", m0_gnt, g0);
        chk("m1_gnt", m1_gnt, g1);
        chk("m0_err", m0_err, g0 & ~al0);
        chk("m1_err", m1_err, g1 & ~al1);
        chk("mem_we", mem_we, e_we);
        chk("mem_re", mem_re, e_re);
        wa = gw1 ? m1_addr : m0_addr;
        wd = gw1 ? m1_wdata : m0_wdata;
        ra = gr1 ? m1_addr : m0_addr;
        if (e_we) begin
            chk("mem_w_addr", mem_w_addr, wa);
            chk("mem_w_data", mem_w_data, wd);
        end
        if (e_re) begin
            chk("mem_r_addr", mem_r_addr, ra);
            rexp = (e_we && (wa == ra)) ? wd : exp_mem[ra[7:2]];
            if (gr1) q1.push_back(rexp); else q0.push_back(rexp);
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (e_we) exp_mem[wa[7:2]] = wd;
            if (gw0 || gw1) ptr_w = gw1;
            if (gr0 || gr1) ptr_r = gr1;
            if (v0 && !g0 && ecnt0 < 15) ecnt0++;
            if (v1 && !g1 && ecnt1 < 15) ecnt1++;
            erv0 = e_re & gr0;
            erv1 = e_re & gr1;
        end
        #1;
        if (kill) begin
            rst_n = 1'b0;
            #1;
            model_reset();
        end
        chk("m0_rvalid", m0_rvalid, erv0);
        chk("m1_rvalid", m1_rvalid, erv1);
        if (erv0 && q0.size() > 0) chk("m0_rdata", m0_rdata, q0.pop_front());
        if (erv1 && q1.size() > 0) chk("m1_rdata", m1_rdata, q1.pop_front());
        chk("m0_stall_cnt", m0_stall_cnt, ecnt0);
        chk("m1_stall_cnt", m1_stall_cnt, ecnt1);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] seq;
        int k0, k1;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        mem_fill = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'hA500_0000 + 32'(i);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        mem_fill = 1'b0;

        // Reset held with both requesting.
        drive(1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0);
        tick(1'b0);
        tick(1'b0);
        chk("rst_m0_gnt", m0_gnt, 1'b0);
        chk("rst_m1_gnt", m1_gnt, 1'b0);
        chk("rst_m1_stall", m1_stall_cnt, 4'd0);
        rst_n = 1'b1;
        #1;
        chk("first_m0_gnt", m0_gnt, 1'b1);
        chk("first_m1_gnt", m1_gnt, 1'b0);
        tick(1'b0);
        drive(1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0);
        #1;
        chk("second_m1_gnt", m1_gnt, 1'b1);
        tick(1'b0);
        chk("second_m1_rdata", m1_rdata, 32'hA500_0001);

        // Concurrent write (m0) and read (m1) of the same address.
        drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("conc_m0_gnt", m0_gnt, 1'b1);
        chk("conc_m1_gnt", m1_gnt, 1'b1);
        tick(1'b0);
        chk("conc_m1_rvalid", m1_rvalid, 1'b1);
        chk("conc_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0);

        // Write fairness from a fresh reset.
        rst_n = 1'b0;
        tick(1'b0);
        rst_n = 1'b1;
        k0 = 0; k1 = 0; seq = 6'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1, 32'h40 + 32'(4 * k0), 32'h1111_0000 + 32'(k0),
                  1'b1, 1'b1, 32'h80 + 32'(4 * k1), 32'h2222_0000 + 32'(k1));
            #1;
            seq[c] = m1_gnt;
            if (m0_gnt) k0++;
            if (m1_gnt) k1++;
            tick(1'b0);
        end
        chk("wr_alternation", {26'h0, seq}, 32'h0000_002A);
        chk("wr_m0_stall", m0_stall_cnt, 4'd3);
        chk("wr_m1_stall", m1_stall_cnt, 4'd3);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        tick(1'b0);
        chk("wr_readback", m1_rdata, 32'h2222_0000);

        // Misaligned read (m1) alongside a misaligned write (m0).
        drive(1'b1, 1'b1, 32'h31, 32'h5555_5555, 1'b1, 1'b0, 32'h22, 32'h0);
        #1;
        chk("mis_m1_gnt", m1_gnt, 1'b1);
        chk("mis_m1_err", m1_err, 1'b1);
        chk("mis_m0_err", m0_err, 1'b1);
        chk("mis_mem_re", mem_re, 1'b0);
        chk("mis_mem_we", mem_we, 1'b0);
        tick(1'b0);
        chk("mis_m1_rvalid", m1_rvalid, 1'b0);

        // Back-to-back reads by m0.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'(4 * k), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            tick(1'b0);
            chk("b2b_m0_rvalid", m0_rvalid, 1'b1);
            chk("b2b_m0_rdata", m0_rdata, 32'hA500_0000 + 32'(k));
        end
        // Same burst again, with reset asserted right after the third accept.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'(4 * k), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            tick(k == 2);
        end
        chk("kill_rvalid_in_rst", m0_rvalid, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("kill_rvalid_after", m0_rvalid, 1'b0);

        // Saturation under continuous read contention.
        k0 = 0; k1 = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1'b1, 1'b0, 32'(4 * (k0 % 16)), 32'h0,
                  1'b1, 1'b0, 32'h40 + 32'(4 * (k1 % 16)), 32'h0);
            #1;
            if (m0_gnt) k0++;
            if (m1_gnt) k1++;
            tick(1'b0);
            if (c == 9) chk("sat_m1_mid", m1_stall_cnt, 4'd5);
        end
        chk("sat_m1_stall", m1_stall_cnt, 4'd15);
        chk("sat_m0_stall", m0_stall_cnt, 4'd15);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the dual-port data memory between the CPU load/store unit (m0) and the DMA/debug engine (m1). The write port and the read port are arbitrated independently with round-robin fairness, so one write and one read from different requesters can issue in the same cycle. The block tracks the one-cycle read latency of the memory and routes returned data to the requester that issued the read. It sits between the requesters and the data memory and drives every memory control and address input.

## Interface
- A_WIDTH, 32, byte address width
- D_WIDTH, 32, data word width
- CNT_WIDTH, 16, width of the per-requester stall counters

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  request valid
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  A_WIDTH  byte address; must be word-aligned
- m0_wdata / m1_wdata  in  D_WIDTH  write data
- m0_gnt / m1_gnt  out  1  request accepted this cycle (combinational)
- m0_err / m1_err  out  1  misaligned request accepted this cycle (combinational, qualifies gnt)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered)
- m0_rdata / m1_rdata  out  D_WIDTH  read data
- m0_stall_cnt / m1_stall_cnt  out  CNT_WIDTH  saturating count of cycles with req=1 and gnt=0
- mem_we, mem_w_addr, mem_w_data  out  1/A_WIDTH/D_WIDTH  memory write port
- mem_re, mem_r_addr  out  1/A_WIDTH  memory read port
- mem_r_data  in  D_WIDTH  memory read data, valid one cycle after mem_re

## Operation
- Write class: requesters with req=1 and we=1. Read class: req=1 and we=0. Each class has its own 2-way round-robin arbiter.
- Arbitration within a class: a sole contender wins. When both contend, the requester other than the class's last winner wins. The last-winner pointer updates on every grant in that class.
- A request is granted when its class arbiter selects it. A requester has only one request per cycle, so both requesters can be granted in the same cycle only when they are in different classes.
- Misaligned request (addr[1:0] != 0):
  - It still wins arbitration and raises gnt and err.
  - It is not issued to memory: mem_we and mem_re stay 0 for it.
  - A misaligned read produces no rvalid.
- Granted aligned write: mem_we=1, with mem_w_addr and mem_w_data taken from the winner.
- Granted aligned read: mem_re=1 and mem_r_addr=addr. The registers rd_pend<=1 and rd_owner<=winner are set.
- Next cycle, while rd_pend=1: the owner's rvalid=1 and its rdata=mem_r_data. The non-owner's rvalid stays 0. Both rdata outputs may carry mem_r_data; only rvalid qualifies it.
- Read and write to the same address in the same cycle: the read returns the new write data (memory write-through). The arbiter does nothing extra.
- Handshake rule: a requester holds req, we, addr and wdata stable until gnt. It may issue its next request in the cycle after gnt, with no wait for rvalid.
- Stall counters increment on req & !gnt and saturate at all-ones. They are never cleared except by reset.

## Timing
- gnt, err, mem_we, mem_re and the memory address/data outputs are combinational from the requests and the pointers. There is zero-cycle accept.
- Read latency is 1 cycle: accept in cycle N, rvalid in cycle N+1. Back-to-back reads give one rvalid per cycle.
- Worst-case wait under continuous contention is 1 cycle.
- While rst_n=0:
  - all gnt, err, rvalid, mem_we and mem_re are 0;
  - rd_pend=0;
  - both last-winner pointers = m1, so m0 wins the first contention;
  - stall counters = 0.
- Reset asserted mid-operation: a pending read is dropped and no rvalid appears after reset is released. Memory contents are not touched.
- Reset deassertion: requests are honoured on the first rising edge with rst_n=1.

## Structure
- Package dmem_arb_pkg holds:
  - the requester index constants REQ_M0=0 and REQ_M1=1;
  - the default width localparams;
  - the alignment-check function.
- Sub-module rr_arb2 is a 2-way round-robin arbiter with req[1:0] in, gnt[1:0] out, and an internal last-winner register with async active-low reset. It is instantiated once for the write class and once for the read class.
- The top level holds the class decode, the alignment check, the read-response registers (rd_pend, rd_owner) and the stall counters.

## Test plan
- **Reset:** hold rst_n=0 with both req=1 → all gnt=0 and stall counts=0. Release reset, with m0 and m1 both reading → m0 granted first, then m1 the next cycle.
- **Concurrent classes:** m0 writes 0xDEADBEEF to 0x10 while m1 reads 0x10 in the same cycle → both gnt=1, and next cycle m1_rvalid=1 with m1_rdata=0xDEADBEEF.
- **Write fairness:** both write continuously for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1, and each stall count reaches 3.
- **Misaligned read:** m1 reads 0x22 → m1_gnt=1, m1_err=1, mem_re=0, and no m1_rvalid in the following cycle.
- **Back-to-back reads:** m0 reads 0x00, 0x04 and 0x08 on consecutive cycles → three consecutive m0_rvalid with the matching data and m1_rvalid=0 throughout. Assert rst_n=0 in the cycle after the third accept → no third rvalid after release.
- **Saturation:** with CNT_WIDTH=4, m1 reads while m0 reads every cycle and the pointer is forced to favour m0 by a long contention pattern → m1_stall_cnt increments per lost cycle and saturates at 15.
